// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - Default address/data widths, reset PC and sequential PC step.
//   - pc_t: program counter type at the default address width.
//   - redirect_src_e: which rule updates fetch state on the next edge.
package instr_fetch_unit_pkg;

  localparam int unsigned DefAddrW  = 4;
  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefPcStep = 1;
  localparam int unsigned DefResetPc = 0;

  typedef logic [DefAddrW-1:0] pc_t;

  // SrcNone means hold (stall); SrcSeq is a normal sequential fetch.
  typedef enum logic [1:0] {
    SrcNone,
    SrcSeq,
    SrcJump,
    SrcBranch
  } redirect_src_e;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection for the instruction fetch unit.
// Priority: jump, then branch (only while an instruction is valid), then stall (hold),
// otherwise sequential fetch. All arithmetic wraps modulo 2^ADDR_W.
// Ports:
//   fetch_pc_i   current fetch address
//   if_valid_i   instruction presented to decode is valid
//   if_pc_4_i    address following the presented instruction
//   stall_i      decode back-pressure
//   jump_en_i / jump_addr_i     absolute redirect
//   branch_en_i / branch_off_i  PC-relative redirect (signed word offset)
//   next_pc_o    fetch address after the edge
//   src_o        rule selected for this edge
module ifu_next_pc
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned OFF_W   = 4,
  parameter int unsigned PC_STEP = DefPcStep
) (
  input  logic [ADDR_W-1:0] fetch_pc_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_4_i,
  input  logic              stall_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              branch_en_i,
  input  logic [OFF_W-1:0]  branch_off_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output redirect_src_e     src_o
);

  logic [ADDR_W-1:0] off_ext;

  // Sized cast of a signed operand sign-extends the offset.
  assign off_ext = ADDR_W'($signed(branch_off_i));

  always_comb begin
    src_o     = SrcNone;
    next_pc_o = fetch_pc_i;
    if (jump_en_i) begin
      src_o     = SrcJump;
      next_pc_o = jump_addr_i;
    end else if (branch_en_i && if_valid_i) begin
      src_o     = SrcBranch;
      next_pc_o = if_pc_4_i + off_ext;
    end else if (!stall_i) begin
      src_o     = SrcSeq;
      next_pc_o = fetch_pc_i + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives a synchronous instruction
// memory with one-cycle read latency and presents instruction, PC and PC+step to decode.
// Supports decode stall, absolute jumps, PC-relative branches and in-flight flush.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   stall                   decode cannot accept, hold fetch state
//   jump_en/jump_addr       absolute redirect
//   branch_en/branch_off    relative redirect from the presented instruction
//   imem_addr/imem_re       memory read request (address = fetch PC)
//   imem_rdata              data for the previous cycle's address
//   if_valid/if_instr/if_pc/if_pc_4  decode-facing outputs
// Optional feature macro IFU_PERF_CNT_EN adds saturating counters perf_fetched and
// perf_redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned PC_STEP  = DefPcStep,
  parameter int unsigned RESET_PC = DefResetPc,
  parameter int unsigned OFF_W    = 4
`ifdef IFU_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_re,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_fetched,
  output logic [CNT_W-1:0]  perf_redirects
`endif
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_valid_q, inflight_valid_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] next_pc;
  redirect_src_e     src;

  ifu_next_pc #(
    .ADDR_W  (ADDR_W),
    .OFF_W   (OFF_W),
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .fetch_pc_i   (fetch_pc_q),
    .if_valid_i   (inflight_valid_q),
    .if_pc_4_i    (if_pc_4),
    .stall_i      (stall),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .branch_en_i  (branch_en),
    .branch_off_i (branch_off),
    .next_pc_o    (next_pc),
    .src_o        (src)
  );

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    unique case (src)
      SrcJump, SrcBranch: begin
        // Flush: the instruction currently in flight is dropped, one bubble follows.
        fetch_pc_d       = next_pc;
        inflight_valid_d = 1'b0;
      end
      SrcSeq: begin
        fetch_pc_d       = next_pc;
        inflight_valid_d = 1'b1;
        inflight_pc_d    = fetch_pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q       <= ADDR_W'(RESET_PC);
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign imem_re   = 1'b1;
  assign if_valid  = inflight_valid_q;
  assign if_pc     = inflight_pc_q;
  assign if_pc_4   = inflight_pc_q + ADDR_W'(PC_STEP);
  assign if_instr  = imem_rdata;

`ifdef IFU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_fetched_q, perf_fetched_d;
  logic [CNT_W-1:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_redirects_d = perf_redirects_q;
    if (inflight_valid_q && !stall && (perf_fetched_q != '1)) begin
      perf_fetched_d = perf_fetched_q + CNT_W'(1);
    end
    if (((src == SrcJump) || (src == SrcBranch)) && (perf_redirects_q != '1)) begin
      perf_redirects_d = perf_redirects_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit at default parameters: directed scenarios followed by a
// randomized phase, checked against a rule-level reference model of the fetch stage.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [3:0]  jump_addr = '0;
  logic        branch_en = 1'b0;
  logic [3:0]  branch_off = '0;
  logic [3:0]  imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [3:0]  if_pc;
  logic [3:0]  if_pc_4;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_redirects;
`endif

  instr_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .imem_addr  (imem_addr),
    .imem_re    (imem_re),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_4    (if_pc_4)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  logic [31:0] mem [16];
  always @(posedge clk) if (imem_re) imem_rdata <= mem[imem_addr];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: address to fetch next, instruction presented to decode, and whether
  // the presented data was freshly read for it (a stall re-reads the next address).
  int m_fetch, m_pc, m_redirects, m_fetched;
  bit m_valid, m_fresh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = 0; m_pc = 0; m_valid = 0; m_fresh = 0;
    m_redirects = 0; m_fetched = 0;
  endtask

  task automatic check_all();
    chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
    chk("imem_re", 32'(imem_re), 32'd1);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    if (m_valid) begin
      chk("if_pc", 32'(if_pc), 32'(m_pc));
      chk("if_pc_4", 32'(if_pc_4), 32'((m_pc + 1) % 16));
      if (m_fresh) chk("if_instr", if_instr, mem[m_pc]);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", 32'(if_pc), 32'd0);
    chk("rst_if_pc_4", 32'(if_pc_4), 32'd1);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_re", 32'(imem_re), 32'd1);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetched", 32'(perf_fetched), 32'd0);
    chk("rst_perf_redirects", 32'(perf_redirects), 32'd0);
`endif
  endtask

  // Apply inputs for one clock, advance the model by the fetch rules, then check.
  task automatic step(input bit s, input bit j, input int ja, input bit b, input int bo);
    int off;
    stall = s; jump_en = j; jump_addr = 4'(ja); branch_en = b; branch_off = 4'(bo);
    off = (bo % 16 >= 8) ? (bo % 16) - 16 : bo % 16;
    if (m_valid && !s) m_fetched++;
    @(posedge clk);
    if (j) begin
      m_fetch = ja % 16; m_valid = 0; m_redirects++;
    end else if (b && m_valid) begin
      m_fetch = (m_pc + 1 + off + 16) % 16; m_valid = 0; m_redirects++;
    end else if (s) begin
      m_fresh = 0;
    end else begin
      m_pc = m_fetch; m_valid = 1; m_fresh = 1; m_fetch = (m_fetch + 1) % 16;
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    model_reset();
    #2;
    check_reset_values();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check_all();

    // Sequential fetch after reset: pc 0,1,2,3.
    run(4);
    chk("seq_pc3", 32'(if_pc), 32'd3);

    // Jump at pc 3 to 0xA: bubble, then 0xA, 0xB.
    step(0, 1, 4'hA, 0, 0);
    chk("jump_bubble", 32'(if_valid), 32'd0);
    run(1);
    chk("jump_target", 32'(if_pc), 32'hA);
    run(1);

    // Reach pc 5, branch -3: bubble, branch during bubble ignored, then pc 3.
    step(0, 1, 4, 0, 0);
    run(2);
    chk("pre_branch_pc", 32'(if_pc), 32'd5);
    step(0, 0, 0, 1, 4'b1101);
    step(0, 0, 0, 1, 5);
    chk("branch_target", 32'(if_pc), 32'd3);

    // Stall 3 cycles at pc 2, then stall+jump to 8, then jump+branch together.
    step(0, 1, 2, 0, 0);
    run(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("stall_pc", 32'(if_pc), 32'd2);
      chk("stall_imem_addr", 32'(imem_addr), 32'd3);
    end
    step(1, 1, 8, 0, 0);
    run(1);
    chk("stall_jump_target", 32'(if_pc), 32'd8);
    step(0, 1, 4'hC, 1, 1);
    run(1);
    chk("jump_over_branch", 32'(if_pc), 32'hC);

    // Wrap from 0xF to 0x0.
    step(0, 1, 4'hE, 0, 0);
    run(2);
    chk("wrap_pc_f", 32'(if_pc), 32'hF);
    chk("wrap_pc_4", 32'(if_pc_4), 32'h0);
    run(1);
    chk("wrap_pc_0", 32'(if_pc), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15),
           $urandom_range(0, 5) == 0, $urandom_range(0, 15));
    end

    // Reset mid-stall, two cycles after a jump.
    step(0, 1, 6, 0, 0);
    run(1);
    step(1, 0, 0, 0, 0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_redirects", 32'(perf_redirects), 32'(m_redirects));
    chk("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
`endif
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    check_all();
    run(3);
    chk("post_reset_pc", 32'(if_pc), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
